// File: rtl/uop_pkg.sv
// Shared definitions for the microcode uop buffer: geometry, slot layout and
// the sequencer state encoding.
package uop_pkg;

    localparam int UOP_BUF_SIZE           = 128;
    localparam int UOP_BUF_WIDTH          = 72;
    localparam int MAX_PREDICT_DEPTH_BITS = 2;
    localparam int UOP_SLOT_WIDTH         = 36;
    localparam int UOP_ADDR_WIDTH         = $clog2(UOP_BUF_SIZE);
    localparam int NUM_TAGS               = 2 ** MAX_PREDICT_DEPTH_BITS;

    // Field offsets inside one 36-bit slot; slot A sits in the upper half.
    localparam int SLOT_VALID_BIT = 0;
    localparam int SLOT_EOS_BIT   = 1;
    localparam int SLOT_TAG_LSB   = 2;
    localparam int SLOT_INSTR_LSB = SLOT_TAG_LSB + MAX_PREDICT_DEPTH_BITS;
    localparam int SLOT_A_LSB     = UOP_SLOT_WIDTH;
    localparam int SLOT_B_LSB     = 0;

    typedef struct packed {
        logic [31:0]                       instr;
        logic [MAX_PREDICT_DEPTH_BITS-1:0] tag;
        logic                              eos;
        logic                              valid;
    } uop_slot_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE_A,
        ISSUE_B,
        DONE
    } seq_state_t;

    function automatic uop_slot_t unpack_slot(input logic [UOP_SLOT_WIDTH-1:0] raw);
        uop_slot_t s;
        s.instr = raw[SLOT_INSTR_LSB +: 32];
        s.tag   = raw[SLOT_TAG_LSB +: MAX_PREDICT_DEPTH_BITS];
        s.eos   = raw[SLOT_EOS_BIT];
        s.valid = raw[SLOT_VALID_BIT];
        return s;
    endfunction

endpackage

// File: rtl/uop_slot_unpack.sv
// Splits one uop buffer bundle into its two issue slots (A issues first).
module uop_slot_unpack
    import uop_pkg::*;
(
    input  logic [UOP_BUF_WIDTH-1:0] bundle,
    output uop_slot_t                slot_a,
    output uop_slot_t                slot_b
);

    assign slot_a = unpack_slot(bundle[SLOT_A_LSB +: UOP_SLOT_WIDTH]);
    assign slot_b = unpack_slot(bundle[SLOT_B_LSB +: UOP_SLOT_WIDTH]);

endmodule

// File: rtl/uop_sequencer.sv
// Walks the uop buffer from a start address and serialises the valid slots of
// each fetched bundle onto a single-instruction issue stream.
module uop_sequencer
    import uop_pkg::*;
(
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [UOP_ADDR_WIDTH-1:0]         start_addr,
    output logic                              busy,
    output logic                              done,
    output logic [UOP_ADDR_WIDTH-1:0]         uop_addr,
    input  logic [UOP_BUF_WIDTH-1:0]          uop,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [31:0]                       out_instr,
    output logic [MAX_PREDICT_DEPTH_BITS-1:0] out_tag,
    output logic                              out_eos,
    input  logic                              redirect_valid,
    input  logic [UOP_ADDR_WIDTH-1:0]         redirect_addr,
    input  logic                              flush_valid,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] flush_tag,
    output seq_state_t                        state
);

    seq_state_t                  state_q, state_d;
    logic [UOP_ADDR_WIDTH-1:0]   pc_q, pc_d, pc_next;
    logic [UOP_BUF_WIDTH-1:0]    bundle_q, bundle_d;
    logic [NUM_TAGS-1:0]         kill_q, kill_d;
    uop_slot_t                   slot_a, slot_b, cur_slot;
    logic                        in_issue, live, slot_exit;

    uop_slot_unpack u_unpack (
        .bundle (bundle_q),
        .slot_a (slot_a),
        .slot_b (slot_b)
    );

    assign cur_slot = (state_q == ISSUE_B) ? slot_b : slot_a;
    assign in_issue = (state_q == ISSUE_A) || (state_q == ISSUE_B);

    // A slot is live unless invalid, killed by an earlier flush, or hit by a
    // flush arriving this very cycle.
    assign live = cur_slot.valid && !kill_q[cur_slot.tag]
               && !(flush_valid && (flush_tag == cur_slot.tag));

    // Issue handshake: a slot transfers on a cycle where out_valid && out_ready.
    // Once raised, out_valid and out_* stay put until that transfer; only a
    // redirect or flush may withdraw them.
    assign out_valid = in_issue && live && !redirect_valid;
    assign out_instr = cur_slot.instr;
    assign out_tag   = cur_slot.tag;
    assign out_eos   = cur_slot.eos;

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign uop_addr = pc_q;
    assign state    = state_q;

    assign pc_next   = (pc_q == UOP_ADDR_WIDTH'(UOP_BUF_SIZE - 1)) ? '0 : pc_q + UOP_ADDR_WIDTH'(1);
    assign slot_exit = !live || out_ready;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        bundle_d = bundle_q;
        kill_d   = kill_q;
        if (state_q != IDLE && flush_valid) begin
            kill_d[flush_tag] = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    pc_d    = start_addr;
                    kill_d  = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_addr;
                end else begin
                    bundle_d = uop;
                    pc_d     = pc_next;
                    state_d  = ISSUE_A;
                end
            end
            ISSUE_A, ISSUE_B: begin
                if (redirect_valid) begin
                    pc_d    = redirect_addr;
                    state_d = FETCH;
                end else if (slot_exit) begin
                    // eos terminates even when the slot itself was squashed
                    if (cur_slot.eos) begin
                        state_d = DONE;
                    end else if (state_q == ISSUE_A) begin
                        state_d = ISSUE_B;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            bundle_q <= '0;
            kill_q   <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            bundle_q <= bundle_d;
            kill_q   <= kill_d;
        end
    end

endmodule

// File: doc/uop_sequencer.md
Name: uop_sequencer

Overview:
Sequences `microcode_unit` execution by walking the uop buffer. The block drives `uop_addr`, latches the 72-bit two-slot bundle returned combinationally on `uop`, and serialises the valid slots into a single-instruction valid/ready stream. It runs one microcode sequence per `start` request, honours branch redirects and tag-based flushes, and terminates on an end-of-sequence slot.

Parameters:
UOP_BUF_SIZE, 128, uop buffer depth; `uop_addr` width is $clog2(UOP_BUF_SIZE).
UOP_BUF_WIDTH, 72, bundle width; two slots of 36 bits.
MAX_PREDICT_DEPTH_BITS, 2, branch tag width; 2**MAX_PREDICT_DEPTH_BITS tags.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  begin a sequence at start_addr; sampled only in IDLE.
start_addr  in  $clog2(UOP_BUF_SIZE)  entry bundle address.
busy  out  1  high in every state except IDLE.
done  out  1  one-cycle pulse when a sequence ends.
uop_addr  out  $clog2(UOP_BUF_SIZE)  bundle address to the uop buffer; equals pc.
uop  in  UOP_BUF_WIDTH  bundle at uop_addr, combinational, same cycle.
out_valid  out  1  issue slot valid.
out_ready  in  1  downstream accepts.
out_instr  out  32  instruction word.
out_tag  out  MAX_PREDICT_DEPTH_BITS  branch tag of issued slot.
out_eos  out  1  issued slot ends the sequence.
redirect_valid  in  1  restart fetch at redirect_addr.
redirect_addr  in  $clog2(UOP_BUF_SIZE)  redirect target.
flush_valid  in  1  squash all slots carrying flush_tag.
flush_tag  in  MAX_PREDICT_DEPTH_BITS  tag to squash.

Behaviour:
- Slot layout: slot A = bundle[71:36] (issued first), slot B = bundle[35:0].
- Within each 36-bit slot: [35:4] instr, [3:2] tag, [1] eos, [0] valid.
- Reset (reset==0, async): state IDLE, pc=0, bundle reg=0, kill_mask=0, busy=0, done=0, out_valid=0.
- States and transitions:
  - IDLE: start=1 -> pc<=start_addr, kill_mask<=0, go to FETCH. redirect_valid and flush_valid are ignored.
  - FETCH: uop_addr=pc. At the edge: bundle<=uop, pc<=pc+1 (wraps UOP_BUF_SIZE-1 -> 0), go to ISSUE_A.
  - ISSUE_A, with live = valid & !kill_mask[tag] & !(flush_valid & flush_tag==tag):
    - live=0: out_valid=0; next state is DONE if eos=1, else ISSUE_B.
    - live=1: out_valid=1 and out_* are driven from the slot.
    - On out_valid & out_ready: next state is DONE if eos, else ISSUE_B. Otherwise hold.
  - ISSUE_B: same rules as ISSUE_A on slot B; a non-eos exit goes to FETCH.
  - DONE: done=1 for exactly one cycle, then IDLE. busy stays 1 in DONE.
- Throughput: 1 FETCH cycle plus 1 cycle per slot (with out_ready=1), i.e. 3 cycles per full bundle.
- Handshake: once asserted, out_valid and out_* are held stable until accepted. The only exceptions are redirect and flush, which may drop out_valid.
- flush_valid (non-IDLE): kill_mask[flush_tag]<=1; the mask is sticky until the next accepted start. The current slot is squashed combinationally in the same cycle, and no handshake occurs even if out_ready=1.
- redirect_valid (non-IDLE, priority over everything including flush and eos):
  - out_valid is forced to 0 that cycle.
  - pc<=redirect_addr, next state FETCH, current bundle discarded.
  - In DONE, the redirect is ignored; done still pulses.
- Eos on a squashed slot still terminates the sequence.
- A bundle with both slots invalid and no eos consumes 2 dead cycles, then the next fetch.
- Reset asserted mid-sequence returns the block immediately to the reset values. No done pulse is produced.

Decomposition:
- Package uop_pkg holds:
  - UOP_BUF_SIZE, UOP_BUF_WIDTH, MAX_PREDICT_DEPTH_BITS and UOP_SLOT_WIDTH=36;
  - the slot field offsets;
  - a packed uop_slot_t struct {instr[31:0], tag, eos, valid};
  - the seq_state_t enum {IDLE, FETCH, ISSUE_A, ISSUE_B, DONE}.
- One sub-module, uop_slot_unpack, is natural: a combinational bundle -> two uop_slot_t split shared with `microcode_unit`.

Test Plan:
- Basic sequence: every bundle in the buffer is {slot A 0x25270004 tag 2 eos 1 valid 1, slot B 0x25270005 tag 2 eos 1 valid 1}. Stimulus: start, start_addr=0, out_ready=1 -> uop_addr=0 in FETCH, one issue of 0x25270004 tag 2 eos 1, done one cycle later; 0x25270005 is never issued.
- Two-bundle run: bundles 5 and 6 with no eos except slot B of bundle 6, out_ready=1, start_addr=5 -> four issues over 6 cycles (FETCH, A, B per bundle), done next, busy low after.
- Backpressure: out_ready=0 for 4 cycles during ISSUE_A -> out_valid and out_instr stable for 4 cycles; exactly one transfer when out_ready rises.
- Redirect and wrap: redirect_valid with redirect_addr=127 while out_ready=1 -> no transfer that cycle, next uop_addr=127, following fetch at 0.
- Flush: flush_valid, flush_tag=2 during ISSUE_A, then later tag-2 slots -> all squashed (out_valid=0); tag-1 slots still issue; a start clears the mask.
- Async reset: reset low mid-ISSUE_B between clock edges -> out_valid, busy and done drop to 0 without a clock edge; uop_addr=0.
